writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/load_align.sv | 40 ++++
 rtl/writeback_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared writeback definitions: load funct3 codes and the writeback entry state.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } wb_state_t;

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/halfword/word lane from an aligned
// memory word and sign- or zero-extends it according to funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (offset)
            2'd0: w_byte = word[7:0];
            2'd1: w_byte = word[15:8];
            2'd2: w_byte = word[23:16];
            2'd3: w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
    end

    // Halfword lane follows offset[1] only; a misaligned offset[0] is ignored.
    assign w_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        value = word;
        case (funct3)
            LB:      value = ext8(w_byte, 1'b1);
            LBU:     value = ext8(w_byte, 1'b0);
            LH:      value = ext16(w_half, 1'b1);
            LHU:     value = ext16(w_half, 1'b0);
            default: value = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Single-entry writeback stage; holds loads until their data arrives.
// Optional 64-bit retire counter enabled by defining WRITEBACK_RETIRE_COUNTER_EN.
//
// state | meaning
// EMPTY | no instruction held, nothing to commit
// FULL  | entry held; commits when not a load or load data is valid
module writeback_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [REG_ADDR_W-1:0] rd_address_in,
    input  logic [XLEN-1:0]       result_in,
    input  logic                  load_in,
    input  logic [2:0]            funct3_in,
    input  logic [XLEN-1:0]       load_data_in,
    input  logic                  load_data_valid_in,
    input  logic                  flush_in,
    output logic                  stall_out,
    output logic [REG_ADDR_W-1:0] rd_address,
    output logic [XLEN-1:0]       rd_data,
`ifdef WRITEBACK_RETIRE_COUNTER_EN
    output logic [63:0]           retire_count,
`endif
    output logic                  retired
);

    wb_state_t             r_state;
    logic [REG_ADDR_W-1:0] r_rd_address;
    logic [XLEN-1:0]       r_result;
    logic                  r_load;
    logic [2:0]            r_funct3;

    logic                  w_commit;
    logic                  w_capture;
    logic [XLEN-1:0]       w_load_value;

    // Reset and flush both suppress the commit so an abandoned entry never writes.
    assign w_commit  = rst_n && !flush_in && (r_state == FULL) &&
                       (!r_load || load_data_valid_in);
    assign stall_out = (r_state == FULL) && !w_commit;
    assign w_capture = valid_in && !stall_out && !flush_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_rd_address <= '0;
            r_result     <= '0;
            r_load       <= 1'b0;
            r_funct3     <= '0;
        end else begin
            if (w_capture) begin
                r_rd_address <= rd_address_in;
                r_result     <= result_in;
                r_load       <= load_in;
                r_funct3     <= funct3_in;
            end
            if (flush_in) begin
                r_state <= EMPTY;
            end else if (w_capture) begin
                r_state <= FULL;
            end else if (w_commit) begin
                r_state <= EMPTY;
            end
        end
    end

    load_align u_load_align (
        .word   (load_data_in),
        .offset (r_result[1:0]),
        .funct3 (r_funct3),
        .value  (w_load_value)
    );

    assign rd_address = w_commit ? r_rd_address : '0;
    assign rd_data    = r_load ? w_load_value : r_result;
    assign retired    = w_commit;

`ifdef WRITEBACK_RETIRE_COUNTER_EN
    logic [63:0] r_retire_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire_count <= '0;
        end else if (w_commit) begin
            r_retire_count <= r_retire_count + 64'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule
